// File: rtl/host_output_transmit_if.sv
// Host transmit port bundle: descriptor in, packet buffer read bus,
// host MAC data out and bufid release toward the buffer manager.
//   master: the transmit block      slave: its environment
interface host_output_transmit_if;
    logic [12:0]  iv_descriptor;
    logic         i_descriptor_wr;
    logic         o_host_outport_free;
    logic [15:0]  ov_pkt_raddr;
    logic         o_pkt_rd;
    logic [133:0] iv_pkt_rdata;
    logic [133:0] ov_data;
    logic         o_data_wr;
    logic [8:0]   ov_bufid_release;
    logic         o_bufid_release_wr;

    modport master (
        input  iv_descriptor,
        input  i_descriptor_wr,
        input  iv_pkt_rdata,
        output o_host_outport_free,
        output ov_pkt_raddr,
        output o_pkt_rd,
        output ov_data,
        output o_data_wr,
        output ov_bufid_release,
        output o_bufid_release_wr
    );

    modport slave (
        output iv_descriptor,
        output i_descriptor_wr,
        output iv_pkt_rdata,
        input  o_host_outport_free,
        input  ov_pkt_raddr,
        input  o_pkt_rd,
        input  ov_data,
        input  o_data_wr,
        input  ov_bufid_release,
        input  o_bufid_release_wr
    );
endinterface

// File: rtl/host_output_transmit.sv
// Host output transmit: reads a scheduled packet out of the buffer and
// streams it to the host MAC, then returns the bufid.
// Ports: i_clk, i_rst_n (async, active low); bus (master modport:
//   descriptor/strobe in, buffer read addr/strobe/data, host data out,
//   bufid release, outport free); ov_htx_state (debug FSM state);
//   ov_host_tx_pkt_cnt only when HOST_TX_PKT_CNT_EN is defined.
module host_output_transmit (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    host_output_transmit_if.master bus,
    output logic [2:0]             ov_htx_state
`ifdef HOST_TX_PKT_CNT_EN
    ,
    output logic [31:0]            ov_host_tx_pkt_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE_S    = 3'd0,
        READ_S    = 3'd1,
        DRAIN_S   = 3'd2,
        RELEASE_S = 3'd3
    } state_t;

    state_t       state;
    logic [8:0]   bufid;
    logic [6:0]   word_cnt;
    logic [1:0]   vld_pipe;
    logic         pkt_rd;
    logic         rel_wr;
    logic [8:0]   rel_id;
    logic         outport_free;

    logic         fwd_en;
    logic         tail_seen;
    logic         last_word;
    logic [133:0] data_out;
    logic         unused_desc;

    // inport field is not needed by this port
    assign unused_desc = ^bus.iv_descriptor[12:9];

    // Returned words are forwarded only while a packet is active, so the
    // over-read words after a tail land in RELEASE_S/IDLE_S and drop.
    always_comb begin
        fwd_en    = vld_pipe[1] &&
                    (state == READ_S || state == DRAIN_S);
        tail_seen = fwd_en &&
                    (bus.iv_pkt_rdata[133:132] == 2'b10);
        // nothing left in flight behind this word: it is address 127
        last_word = (state == DRAIN_S) && vld_pipe[1] &&
                    !vld_pipe[0] && !pkt_rd;
    end

    always_comb begin
        data_out = '0;
        if (fwd_en) begin
            data_out = bus.iv_pkt_rdata;
            if (last_word) begin
                data_out[133:132] = 2'b10;
            end
        end
    end

    assign bus.ov_data             = data_out;
    assign bus.o_data_wr           = fwd_en;
    assign bus.o_pkt_rd            = pkt_rd;
    assign bus.ov_pkt_raddr        = pkt_rd ? {bufid, word_cnt} : 16'd0;
    assign bus.ov_bufid_release    = rel_id;
    assign bus.o_bufid_release_wr  = rel_wr;
    assign bus.o_host_outport_free = outport_free;
    assign ov_htx_state            = state;

    // word_cnt is the address of the read on the bus this cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE_S;
            bufid        <= 9'd0;
            word_cnt     <= 7'd0;
            vld_pipe     <= 2'b00;
            pkt_rd       <= 1'b0;
            rel_wr       <= 1'b0;
            rel_id       <= 9'd0;
            outport_free <= 1'b0;
        end else begin
            vld_pipe     <= {vld_pipe[0], pkt_rd};
            rel_wr       <= 1'b0;
            rel_id       <= 9'd0;
            outport_free <= 1'b0;
            unique case (state)
                IDLE_S: begin
                    pkt_rd <= 1'b0;
                    if (bus.i_descriptor_wr) begin
                        bufid    <= bus.iv_descriptor[8:0];
                        word_cnt <= 7'd0;
                        pkt_rd   <= 1'b1;
                        state    <= READ_S;
                    end
                end
                READ_S: begin
                    if (tail_seen) begin
                        pkt_rd       <= 1'b0;
                        rel_wr       <= 1'b1;
                        rel_id       <= bufid;
                        outport_free <= 1'b1;
                        state        <= RELEASE_S;
                    end else if (word_cnt == 7'd127) begin
                        pkt_rd <= 1'b0;
                        state  <= DRAIN_S;
                    end else begin
                        word_cnt <= word_cnt + 7'd1;
                    end
                end
                DRAIN_S: begin
                    pkt_rd <= 1'b0;
                    if (tail_seen || last_word) begin
                        rel_wr       <= 1'b1;
                        rel_id       <= bufid;
                        outport_free <= 1'b1;
                        state        <= RELEASE_S;
                    end
                end
                RELEASE_S: begin
                    pkt_rd <= 1'b0;
                    state  <= IDLE_S;
                end
                default: begin
                    pkt_rd <= 1'b0;
                    state  <= IDLE_S;
                end
            endcase
        end
    end

`ifdef HOST_TX_PKT_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_host_tx_pkt_cnt <= 32'd0;
        end else if (rel_wr) begin
            ov_host_tx_pkt_cnt <= ov_host_tx_pkt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_host_output_transmit.sv
// Randomized bench for host_output_transmit with a packet buffer
// responder and a rule-based expected-stream model.
module tb_host_output_transmit;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    host_output_transmit_if bus ();
    logic [2:0] htx_state;
`ifdef HOST_TX_PKT_CNT_EN
    logic [31:0] pkt_cnt;
`endif

    host_output_transmit dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .bus          (bus.master),
        .ov_htx_state (htx_state)
`ifdef HOST_TX_PKT_CNT_EN
        ,
        .ov_host_tx_pkt_cnt (pkt_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [133:0] got,
                         input logic [133:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // packet buffer: data appears 2 cycles after the read strobe
    logic [133:0] mem [0:65535];
    logic [15:0]  a_d1, a_d2;
    logic         r_d1 = 1'b0;
    logic         r_d2 = 1'b0;
    logic [133:0] garbage = {2'b10, 132'hDEAD_BEEF_0BAD_F00D};

    always @(posedge i_clk) begin
        a_d1 <= bus.ov_pkt_raddr;
        r_d1 <= bus.o_pkt_rd;
        a_d2 <= a_d1;
        r_d2 <= r_d1;
    end
    assign bus.iv_pkt_rdata = r_d2 ? mem[a_d2] : garbage;

    // cycle label and output monitor
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int           c;
        logic [133:0] d;
    } ev_t;

    ev_t dq[$];
    ev_t rq[$];
    ev_t relq[$];
    ev_t freeq[$];
    int  viol = 0;

    always @(negedge i_clk) begin
        ev_t e;
        e.c = cyc;
        if (bus.o_data_wr) begin
            e.d = bus.ov_data;
            dq.push_back(e);
        end
        if (bus.o_pkt_rd) begin
            e.d = {118'd0, bus.ov_pkt_raddr};
            rq.push_back(e);
        end
        if (bus.o_bufid_release_wr) begin
            e.d = {122'd0, htx_state, bus.ov_bufid_release};
            relq.push_back(e);
        end
        if (bus.o_host_outport_free) begin
            e.d = '0;
            freeq.push_back(e);
        end
        if (!bus.o_data_wr && bus.ov_data != '0) viol++;
        if (!bus.o_bufid_release_wr && bus.ov_bufid_release != '0) viol++;
    end

    task automatic clear_mon();
        dq.delete();
        rq.delete();
        relq.delete();
        freeq.delete();
        viol = 0;
    endtask

    // len 1..128: tail at word len-1; len > 128: no tail at all
    task automatic fill_pkt(input logic [8:0] bid, input int len);
        logic [1:0]   tag;
        logic [131:0] pay;
        for (int i = 0; i < 128; i++) begin
            tag = (i == len - 1) ? 2'b10 : ((i == 0) ? 2'b01 : 2'b11);
            pay = {$urandom, $urandom, $urandom, $urandom, 4'($urandom)};
            mem[{bid, 7'(i)}] = {tag, pay};
        end
    endtask

    // Host sees the words up to the first tail, or the first 128 with
    // the last one re-tagged as a tail.
    task automatic build_exp(input logic [8:0] bid,
                             output logic [133:0] exp[$]);
        logic [133:0] w;
        exp.delete();
        for (int i = 0; i < 128; i++) begin
            w = mem[{bid, 7'(i)}];
            if (i == 127) w[133:132] = 2'b10;
            exp.push_back(w);
            if (w[133:132] == 2'b10) break;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_wr"}, bus.o_data_wr, 0);
        check({tag, "_data"}, bus.ov_data, 0);
        check({tag, "_rd"}, bus.o_pkt_rd, 0);
        check({tag, "_raddr"}, bus.ov_pkt_raddr, 0);
        check({tag, "_rel_wr"}, bus.o_bufid_release_wr, 0);
        check({tag, "_rel_id"}, bus.ov_bufid_release, 0);
        check({tag, "_free"}, bus.o_host_outport_free, 0);
        check({tag, "_state"}, htx_state, 0);
    endtask

    // mode 0: plain; 1: extra descriptor in READ_S;
    // 2: extra descriptor in the release cycle
    task automatic run_pkt(input logic [12:0] desc, input int len,
                           input int mode);
        logic [8:0]   bid;
        logic [133:0] exp[$];
        int           t0, n, nmax, nrd;
        bit           done, ok;
        bid = desc[8:0];
        fill_pkt(bid, len);
        build_exp(bid, exp);
        n = exp.size();
        nmax = (n + 2 > 128) ? 128 : n + 2;
        @(negedge i_clk);
        clear_mon();
        t0 = cyc;
        bus.iv_descriptor = desc;
        bus.i_descriptor_wr = 1'b1;
        @(negedge i_clk);
        bus.i_descriptor_wr = 1'b0;
        bus.iv_descriptor = 13'($urandom);
        check("state_read", htx_state, 1);
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge i_clk);
            bus.i_descriptor_wr = 1'b0;
            if (mode == 1 && cyc == t0 + 2) begin
                bus.iv_descriptor = {4'h3, bid ^ 9'h1AA};
                bus.i_descriptor_wr = 1'b1;
            end
            if (mode == 2 && cyc == t0 + 3 + n) begin
                bus.iv_descriptor = {4'h6, bid ^ 9'h055};
                bus.i_descriptor_wr = 1'b1;
            end
            if (relq.size() > 0 && cyc >= relq[0].c + 6) done = 1;
        end
        bus.i_descriptor_wr = 1'b0;
        check("release_seen", done, 1);
        check("n_words", dq.size(), n);
        for (int i = 0; i < dq.size() && i < n; i++) begin
            check("word", dq[i].d, exp[i]);
            check("word_cyc", dq[i].c, t0 + 3 + i);
        end
        check("n_release", relq.size(), 1);
        if (relq.size() > 0) begin
            check("rel_id_state", relq[0].d, {122'd0, 3'd3, bid});
            check("rel_cyc", relq[0].c, t0 + 3 + n);
        end
        check("n_free", freeq.size(), 1);
        if (freeq.size() > 0) check("free_cyc", freeq[0].c, t0 + 3 + n);
        nrd = rq.size();
        check("rd_first_cyc", (nrd > 0) ? rq[0].c : -1, t0 + 1);
        check("rd_count", (nrd >= n && nrd <= nmax), 1);
        ok = 1;
        for (int i = 0; i < nrd; i++) begin
            if (rq[i].d[15:0] != {bid, 7'(i)}) ok = 0;
            if (rq[i].c != t0 + 1 + i) ok = 0;
        end
        check("rd_seq", ok, 1);
        check("zero_gate", viol, 0);
    endtask

    task automatic reset_pulse();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    initial begin
        int nd;
        bus.iv_descriptor = '0;
        bus.i_descriptor_wr = 1'b0;
        repeat (2) @(negedge i_clk);
        check_outputs_zero("reset");
`ifdef HOST_TX_PKT_CNT_EN
        check("reset_cnt", pkt_cnt, 0);
`endif
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // directed: 3-word, tail-only, truncation, tail at word 127
        run_pkt(13'h1005, 3, 0);
        run_pkt(13'h0133, 1, 0);
        run_pkt(13'h0A47, 130, 0);
        run_pkt(13'h0121, 128, 0);
        run_pkt(13'h0088, 4, 1);
        run_pkt(13'h1FF0, 2, 2);

        // reset on the 2nd data word
        fill_pkt(9'h0C3, 6);
        @(negedge i_clk);
        clear_mon();
        bus.iv_descriptor = 13'h00C3;
        bus.i_descriptor_wr = 1'b1;
        @(negedge i_clk);
        bus.i_descriptor_wr = 1'b0;
        nd = 0;
        for (int i = 0; i < 20 && nd < 2; i++) begin
            @(negedge i_clk);
            if (bus.o_data_wr) nd++;
        end
        check("rst_wait", nd, 2);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check_outputs_zero("mid_rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (10) @(negedge i_clk);
        check("rst_no_release", relq.size(), 0);
        check("rst_no_free", freeq.size(), 0);
        run_pkt(13'h0C3, 5, 0);

        // randomized packets
        for (int k = 0; k < 12; k++) begin
            int len;
            len = (k % 5 == 4) ? int'($urandom_range(120, 135))
                               : int'($urandom_range(1, 14));
            run_pkt(13'($urandom), len, int'($urandom_range(0, 2)));
        end

`ifdef HOST_TX_PKT_CNT_EN
        reset_pulse();
        check("cnt_after_rst", pkt_cnt, 0);
        for (int k = 0; k < 4; k++) begin
            run_pkt(13'($urandom), int'($urandom_range(1, 6)), 0);
        end
        check("cnt_four", pkt_cnt, 4);
        force dut.ov_host_tx_pkt_cnt = 32'hFFFF_FFFF;
        @(negedge i_clk);
        release dut.ov_host_tx_pkt_cnt;
        @(negedge i_clk);
        check("cnt_preset", pkt_cnt, 32'hFFFF_FFFF);
        run_pkt(13'h0042, 3, 0);
        check("cnt_wrap", pkt_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/host_output_transmit.md
HOST_OUTPUT_TRANSMIT -- requirements
Module: host_output_transmit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: i_clk, i_rst_n.
REQ-002 The port list SHALL be as follows:
- i_clk  in  1  clock.
- i_rst_n  in  1  async active-low reset.
- iv_descriptor  in  13  scheduled descriptor; [12:9] inport, [8:0] bufid.
- i_descriptor_wr  in  1  one-cycle descriptor-valid strobe.
- o_host_outport_free  out  1  one-cycle pulse when the port can accept the next descriptor.
- ov_pkt_raddr  out  16  packet buffer read address {bufid, word_cnt[6:0]}.
- o_pkt_rd  out  1  packet buffer read strobe.
- iv_pkt_rdata  in  134  buffer read data; valid exactly 2 cycles after o_pkt_rd.
- ov_data  out  134  word to host MAC; [133:132] 01 head, 11 body, 10 tail.
- o_data_wr  out  1  host data valid.
- ov_bufid_release  out  9  bufid returned to the buffer manager.
- o_bufid_release_wr  out  1  release strobe.
- ov_htx_state  out  3  current FSM state, for debug.
- ov_host_tx_pkt_cnt  out  32  transmitted packet count; present only with the Configuration macro.

Function
REQ-003 The FSM SHALL have states IDLE_S=0, READ_S=1, DRAIN_S=2, RELEASE_S=3; ov_htx_state SHALL equal the state.
REQ-004 IDLE_S: on i_descriptor_wr=1, latch bufid=iv_descriptor[8:0], clear word_cnt and go to READ_S; other descriptor bits SHALL be ignored.
REQ-005 READ_S: assert o_pkt_rd=1 every cycle with ov_pkt_raddr={bufid,word_cnt}, then increment word_cnt.
REQ-006 A 2-stage valid shift register SHALL track issued reads; each returned word SHALL drive ov_data=iv_pkt_rdata with o_data_wr=1.
REQ-007 When a returned word has [133:132]=2'b10, the FSM SHALL stop reads immediately and discard any later returned words (o_data_wr=0); at most 2 extra reads are tolerated.
REQ-008 When the tail is seen in READ_S with no further valid words to forward, the FSM SHALL go to RELEASE_S; DRAIN_S is entered only when word_cnt saturates.
REQ-009 If word_cnt reaches 127 and no tail has returned, reads SHALL stop and the FSM SHALL enter DRAIN_S.
REQ-010 DRAIN_S SHALL forward the outstanding words; the word at address 127 SHALL be output with [133:132] forced to 2'b10 (truncation); then go to RELEASE_S.
REQ-011 RELEASE_S (one cycle): ov_bufid_release=bufid, o_bufid_release_wr=1, o_host_outport_free=1, then return to IDLE_S.
REQ-012 Latency SHALL be as follows:
- first o_pkt_rd on the cycle after i_descriptor_wr;
- first o_data_wr 2 cycles after the first o_pkt_rd;
- release 1 cycle after the tail is output.
REQ-013 An i_descriptor_wr that arrives outside IDLE_S SHALL be ignored.
REQ-014 An i_descriptor_wr that arrives in the same cycle as the release pulse SHALL be ignored; the next descriptor is accepted from IDLE_S.
REQ-015 ov_data and ov_bufid_release SHALL be 0 when their strobes are 0.

Reset
REQ-016 On i_rst_n=0, all outputs SHALL be 0, the FSM SHALL be IDLE_S, and word_cnt, the valid pipe and ov_host_tx_pkt_cnt SHALL be 0.
REQ-017 A reset asserted mid-packet SHALL abort the packet without a release or free pulse; the bufid is recovered by the buffer manager's own reset.

Configuration
REQ-018 With HOST_TX_PKT_CNT_EN defined, ov_host_tx_pkt_cnt SHALL increment by 1 on each o_bufid_release_wr and wrap from 0xFFFFFFFF to 0.
REQ-019 Without HOST_TX_PKT_CNT_EN, the ov_host_tx_pkt_cnt port and counter SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- 3-word packet: descriptor 0x1005 (bufid 5) at t0 -> reads 0x0280..0x0282 from t0+1; data t0+3..t0+5 (01,11,10); release bufid 5 plus free at t0+6; 2 extra reads discarded.
- Single-word tail-only packet (10) -> exactly 1 o_data_wr, then release.
- 130-word packet with no tail -> 128 words output, last word tagged 10; release bufid.
- Descriptor injected during READ_S -> ignored; only the first bufid is released.
- Reset asserted at the 2nd data word -> all outputs 0 next cycle; no release; a new descriptor after reset is processed normally.
- HOST_TX_PKT_CNT_EN defined, 4 packets -> counter=4; preset 0xFFFFFFFF plus 1 packet -> counter=0.
